// File: rtl/unary_add_sched.sv
// rtl/unary_add_sched.sv - two-requester scheduler for a shared unary (thermometer) adder.
// Optional UNARY_ADD_SCHED_SAT_EN: saturate sum at LEN and report overflow from the adder carry.
module unary_add_sched #(
  parameter int LEN = 12,
  parameter int OW  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [OW-1:0] opa0,
  input  logic [OW-1:0] opb0,
  input  logic [OW-1:0] opa1,
  input  logic [OW-1:0] opb1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic [OW:0]   sum,
  output logic          ovf,
  output logic          add_A,
  output logic          add_B,
  output logic          add_en,
  output logic          add_read_or_write,
  output logic          add_rst_n,
  input  logic          add_dout,
  input  logic          add_C
);

  typedef enum logic [2:0] {IDLE, CLR, READ, WRITE, DONE} state_t;

  localparam logic [OW-1:0] K_READ_LAST  = OW'(LEN - 1);
  localparam logic [OW-1:0] K_WRITE_LAST = OW'(LEN);
  localparam logic [OW:0]   CNT_MAX      = '1;

  state_t        state;
  logic [OW-1:0] k;
  logic [OW-1:0] opa_q;
  logic [OW-1:0] opb_q;
  logic [OW:0]   cnt;
  logic          owner;
  logic          last_gnt;
  logic          win;

`ifdef UNARY_ADD_SCHED_SAT_EN
  localparam logic [OW:0] LEN_W = (OW+1)'(LEN);
  logic c_seen;
`else
  logic unused_add_c;
  assign unused_add_c = add_C;
`endif

  // Round-robin: on a tie the requester not granted last wins.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) win = ~last_gnt;
    else              win = req[1];
  end

  // Outputs are registered with the state, so each branch loads the values for the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      k                 <= '0;
      opa_q             <= '0;
      opb_q             <= '0;
      cnt               <= '0;
      owner             <= 1'b0;
      last_gnt          <= 1'b1;
      gnt               <= 2'b00;
      done              <= 2'b00;
      sum               <= '0;
      ovf               <= 1'b0;
      add_A             <= 1'b0;
      add_B             <= 1'b0;
      add_en            <= 1'b0;
      add_read_or_write <= 1'b0;
      add_rst_n         <= 1'b0;
`ifdef UNARY_ADD_SCHED_SAT_EN
      c_seen            <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          gnt               <= 2'b00;
          done              <= 2'b00;
          add_rst_n         <= 1'b1;
          add_en            <= 1'b0;
          add_read_or_write <= 1'b0;
          add_A             <= 1'b0;
          add_B             <= 1'b0;
          if (req != 2'b00 && done == 2'b00) begin
            owner     <= win;
            last_gnt  <= win;
            gnt       <= win ? 2'b10 : 2'b01;
            opa_q     <= win ? opa1 : opa0;
            opb_q     <= win ? opb1 : opb0;
            add_rst_n <= 1'b0;
            state     <= CLR;
          end
        end
        CLR: begin
          gnt               <= 2'b00;
          add_rst_n         <= 1'b1;
          add_en            <= 1'b1;
          add_read_or_write <= 1'b0;
          k                 <= '0;
          cnt               <= '0;
          add_A             <= (opa_q != '0);
          add_B             <= (opb_q != '0);
`ifdef UNARY_ADD_SCHED_SAT_EN
          c_seen            <= 1'b0;
`endif
          state             <= READ;
        end
        READ: begin
          if (k == K_READ_LAST) begin
            k                 <= '0;
            add_A             <= 1'b0;
            add_B             <= 1'b0;
            add_read_or_write <= 1'b1;
            state             <= WRITE;
          end else begin
            k     <= k + OW'(1);
            add_A <= (k + OW'(1)) < opa_q;
            add_B <= (k + OW'(1)) < opb_q;
          end
        end
        WRITE: begin
          // The adder output lags by one cycle, so the first write cycle is skipped.
          if (k != '0) begin
            if (add_dout && cnt != CNT_MAX) cnt <= cnt + (OW+1)'(1);
`ifdef UNARY_ADD_SCHED_SAT_EN
            if (add_C) c_seen <= 1'b1;
`endif
          end
          if (k == K_WRITE_LAST) begin
            add_en            <= 1'b0;
            add_read_or_write <= 1'b0;
            state             <= DONE;
          end else begin
            k <= k + OW'(1);
          end
        end
        DONE: begin
          done <= owner ? 2'b10 : 2'b01;
`ifdef UNARY_ADD_SCHED_SAT_EN
          sum  <= (cnt > LEN_W) ? LEN_W : cnt;
          ovf  <= c_seen || (cnt > LEN_W);
`else
          sum  <= cnt;
          ovf  <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unary_add_sched.sv
// tb/tb_unary_add_sched.sv - randomized self-checking bench for unary_add_sched with a behavioural unary adder.
module tb_unary_add_sched;
  localparam int LEN = 12;
  localparam int OW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req;
  logic [OW-1:0] opa0, opb0, opa1, opb1;
  logic [1:0]    gnt, done;
  logic [OW:0]   sum;
  logic          ovf;
  logic          add_A, add_B, add_en, add_read_or_write, add_rst_n;
  logic          add_dout, add_C;

  int checks = 0;
  int failures = 0;
  int last_model = 1;
  bit force_c = 1'b0;

  int acc = 0;
  int emitted = 0;

  always #5 clk = ~clk;

  unary_add_sched #(.LEN(LEN), .OW(OW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .opa0(opa0), .opb0(opb0), .opa1(opa1), .opb1(opb1),
    .gnt(gnt), .done(done), .sum(sum), .ovf(ovf),
    .add_A(add_A), .add_B(add_B), .add_en(add_en),
    .add_read_or_write(add_read_or_write), .add_rst_n(add_rst_n),
    .add_dout(add_dout), .add_C(add_C)
  );

  // Unary adder: accumulate ones while reading, replay them as a thermometer stream while writing.
  always @(posedge clk) begin
    if (!add_rst_n) begin
      acc <= 0; emitted <= 0; add_dout <= 1'b0; add_C <= 1'b0;
    end else if (add_en && !add_read_or_write) begin
      acc <= acc + int'(add_A) + int'(add_B);
      add_dout <= 1'b0; add_C <= 1'b0;
    end else if (add_en && add_read_or_write) begin
      add_dout <= (emitted < acc);
      emitted <= emitted + 1;
      add_C <= force_c || (acc > LEN);
    end else begin
      add_dout <= 1'b0; add_C <= 1'b0;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int clip(input int v);
    return (v > LEN) ? LEN : v;
  endfunction

  task automatic run_round(input logic [1:0] pat, input bit drop_mid);
    logic [1:0] pend;
    int w, gap, lat, na, nb, ea, eb, es, eo;
    bit chained;
    pend = pat;
    req = pat;
    chained = 1'b0;
    while (pend != 2'b00) begin
      gap = 0;
      do begin @(negedge clk); gap++; end while (gnt == 2'b00 && gap < 10);
      w = (pend == 2'b11) ? (1 - last_model) : (pend[1] ? 1 : 0);
      check("gnt", gnt, 1 << w);
      if (chained) check("grant_gap", gap, 2);
      last_model = w;
      ea = clip(w ? int'(opa1) : int'(opa0));
      eb = clip(w ? int'(opb1) : int'(opb0));
      es = clip(ea + eb);
`ifdef UNARY_ADD_SCHED_SAT_EN
      eo = (force_c || (ea + eb > LEN)) ? 1 : 0;
`else
      eo = 0;
`endif
      if (w == 1) begin opa1 = OW'($urandom); opb1 = OW'($urandom); end
      else        begin opa0 = OW'($urandom); opb0 = OW'($urandom); end
      if (drop_mid) req[w] = 1'b0;
      lat = 0; na = 0; nb = 0;
      do begin
        @(negedge clk); lat++;
        na += int'(add_A); nb += int'(add_B);
      end while (done == 2'b00 && lat < 100);
      check("latency", lat, 2*LEN + 3);
      check("done", done, 1 << w);
      check("sum", sum, es);
      check("ovf", ovf, eo);
      check("a_ones", na, ea);
      check("b_ones", nb, eb);
      req[w] = 1'b0;
      pend[w] = 1'b0;
      chained = (pend != 2'b00);
    end
  endtask

  initial begin
    int n, ndone;
    rst_n = 1'b0; req = 2'b00;
    opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_ovf", ovf, 0);
    check("rst_add_en", add_en, 0);
    check("rst_add_rst_n", add_rst_n, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("add_rst_n_release", add_rst_n, 1);

    // Tie from reset: requester 0 first, then 1.
    opa0 = 4'd5; opb0 = 4'd2; opa1 = 4'd1; opb1 = 4'd6;
    run_round(2'b11, 1'b0);
    opa0 = 4'd3; opb0 = 4'd4;
    run_round(2'b01, 1'b0);
    opa0 = 4'd12; opb0 = 4'd12; force_c = 1'b1;
    run_round(2'b01, 1'b0);
    force_c = 1'b0;
    opa1 = 4'd0; opb1 = 4'd0;
    run_round(2'b10, 1'b0);

    for (int i = 0; i < 25; i++) begin
      n = $urandom_range(0, 3);
      repeat (n) @(negedge clk);
      opa0 = OW'($urandom); opb0 = OW'($urandom);
      opa1 = OW'($urandom); opb1 = OW'($urandom);
      force_c = ($urandom_range(0, 3) == 0);
      run_round(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
    end
    force_c = 1'b0;

    // Reset while reading at k=5.
    opa0 = 4'd9; opb0 = 4'd9; req = 2'b01;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == 2'b00 && n < 10);
    check("pre_rst_gnt", gnt, 1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0; req = 2'b00;
    #1;
    check("midrst_gnt", gnt, 0);
    check("midrst_done", done, 0);
    check("midrst_sum", sum, 0);
    check("midrst_A", add_A, 0);
    check("midrst_B", add_B, 0);
    check("midrst_en", add_en, 0);
    check("midrst_rw", add_read_or_write, 0);
    check("midrst_add_rst_n", add_rst_n, 0);
    last_model = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done != 2'b00) ndone++; end
    check("no_done_after_rst", ndone, 0);
    opa0 = OW'($urandom); opb0 = OW'($urandom);
    opa1 = OW'($urandom); opb1 = OW'($urandom);
    run_round(2'b11, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/unary_add_sched.md
UNARY_ADD_SCHED -- requirements
Module: unary_add_sched

Interface
REQ-001 Parameter LEN, default 12, SHALL set the unary stream length in cycles, valid range 2..15.
REQ-002 Parameter OW, default 4, SHALL set the operand width, with LEN <= 2**OW-1.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-005 req[1:0]  input  2  SHALL be level requests from requesters 0 and 1, held high until the matching done bit.
REQ-006 opa0, opb0, opa1, opb1  input  OW each  SHALL be per-requester operand counts, sampled only at grant.
REQ-007 gnt[1:0]  output  2  SHALL be a one-cycle one-hot grant pulse.
REQ-008 done[1:0]  output  2  SHALL be a one-cycle one-hot completion pulse.
REQ-009 sum  output  OW+1  SHALL be the result count, valid while any done bit is high.
REQ-010 ovf  output  1  SHALL be the overflow flag, valid with done.
REQ-011 add_A, add_B, add_en, add_read_or_write, add_rst_n  output  1 each  SHALL drive the shared unary adder inputs A, B, en, read_or_write, rst_n.
REQ-012 add_dout, add_C  input  1 each  SHALL be the adder outputs dout and C.

Function
REQ-013 FSM states SHALL be IDLE, CLR, READ, WRITE, DONE.
REQ-014 IDLE->CLR SHALL occur when any req bit is high and no done bit is high in that cycle; the arbiter picks the winner, pulses gnt, and latches the winner's operands.
REQ-015 Arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins; the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-016 CLR SHALL last 1 cycle with add_rst_n=0 and add_en=0, then go to READ.
REQ-017 READ SHALL last exactly LEN cycles with add_en=1 and add_read_or_write=0, using a cycle index k=0..LEN-1.
REQ-018 In READ, add_A SHALL equal (k < latched opa) and add_B SHALL equal (k < latched opb), forming thermometer streams; operands above LEN behave as LEN.
REQ-019 WRITE SHALL last LEN+1 cycles with add_en=1, add_read_or_write=1, and add_A=add_B=0.
REQ-020 In WRITE, add_dout SHALL be counted on cycles 2..LEN+1 (one-cycle adder latency), and add_C SHALL be ORed over the same cycles.
REQ-021 DONE SHALL last 1 cycle, pulse done for the granted requester, present sum and ovf, then return to IDLE.
REQ-022 Latency SHALL be fixed: gnt to done equals 2*LEN+3 cycles, independent of operand values.
REQ-023 Operand or req changes outside the grant cycle SHALL have no effect on the operation in flight.
REQ-024 A req dropped mid-operation SHALL NOT abort it; done still pulses.
REQ-025 The result counter SHALL NOT wrap; it holds at 2**(OW+1)-1.

Reset
REQ-026 On rst_n low, the FSM SHALL enter IDLE immediately, regardless of the operation in flight.
REQ-027 On rst_n low, gnt, done, sum, ovf, add_A, add_B, add_en, and add_read_or_write SHALL be 0, add_rst_n SHALL be 0, and the last-grant pointer SHALL be 1.
REQ-028 add_rst_n SHALL return to 1 on the first clock after reset release.
REQ-029 No done SHALL be issued for an operation interrupted by reset.

Configuration
REQ-030 Macro UNARY_ADD_SCHED_SAT_EN defined: sum SHALL saturate at LEN, and ovf SHALL be set if add_C was seen or the raw count exceeded LEN.
REQ-031 Macro UNARY_ADD_SCHED_SAT_EN undefined: sum SHALL be the raw count, ovf SHALL be tied 0, and add_C SHALL be ignored.

Verification
REQ-032 req=01, opa0=3, opb0=4, LEN=12 -> gnt=01, then done=01 27 cycles later with sum=7, ovf=0.
REQ-033 req=11 from reset, both held -> grants 01 then 10, with no gap other than one IDLE cycle; each result is correct.
REQ-034 opa0=12, opb0=12, adder asserting C, SAT_EN defined -> sum=12, ovf=1; SAT_EN undefined -> sum equals the raw dout count, ovf=0.
REQ-035 rst_n pulsed low during READ k=5 -> all outputs 0 within the same cycle; no done; the next req restarts from CLR.
REQ-036 opa1=0, opb1=0 -> add_A=add_B=0 throughout READ; sum=0 at done.
